alu_arbiter_64: RTL and testbench
=================================

# alu_arbiter_64

Two-requester round-robin arbiter and two-stage issue pipeline that shares one combinational 64-bit ALU (bitwise AND/OR/XOR, ADD, SUB) in the EX area of the 5-stage pipeline. Each requester presents an opcode and two operands with a valid/ready handshake. The block registers the winning request, drives the shared ALU from that register, and captures the ALU output into a response register tagged with the requester ID. Full throughput is one operation per cycle, with backpressure from the response side.

## Interface
- DATA_W, 64, operand/result width
- OPC_W, 3, opcode width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (valid & ready)
- req0_op / req1_op  in  OPC_W  operation code
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands
- alu_op  out  OPC_W  opcode to shared ALU (from issue register)
- alu_a, alu_b  out  DATA_W  operands to shared ALU (from issue register)
- alu_y  in  DATA_W  combinational ALU result for alu_op/alu_a/alu_b
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the operation
- rsp_data  out  DATA_W  result
- rsp_err  out  1  opcode was illegal (101–111); rsp_data forced to 0

## Operation
- Stage S1 (issue register): s1_valid, s1_id, s1_op, s1_a, s1_b. It drives alu_* continuously. When s1_valid=0, alu_* hold their last value (no toggling requirement).
- Stage S2 (response register): rsp_valid, rsp_id, rsp_data, rsp_err.
- s2_free = !rsp_valid | rsp_ready. s1_free = !s1_valid | s2_free.
- Arbitration: last_grant is a 1-bit register.
  - Only one requester valid: grant it.
  - Both valid: grant the one != last_grant.
  - last_grant updates only on an accepted handshake.
- reqX_ready = s1_free & grant==X. It is combinational from valids, last_grant, s1/rsp state and rsp_ready. It must not depend on reqX_op/a/b.
- Accept: S1 loads the granted requester's op/a/b/id, and s1_valid <= 1.
- S1→S2 move when s1_valid & s2_free:
  - rsp_data <= illegal ? 0 : alu_y.
  - rsp_err <= illegal.
  - rsp_id <= s1_id.
  - rsp_valid <= 1.
- If S1 moves and nothing is accepted, s1_valid <= 0.
- If rsp_ready & rsp_valid and S1 is empty, rsp_valid <= 0.
- Simultaneous drain, move and accept in one cycle is legal and required, giving full throughput.
- No wrap or overflow handling is needed here: ADD/SUB wrap modulo 2^64 inside the ALU.

## Timing
- Reset (async assert, sync release by upstream): s1_valid=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, last_grant=1 (requester 0 wins the first tie), alu_op/alu_a/alu_b=0.
- Latency: accept at edge N; result visible on rsp_* after edge N+1 (one cycle in S1, ALU path in that cycle).
- Backpressure: with rsp_ready=0 and both stages full, both req*_ready=0. The response stays stable until accepted.
- Reset mid-operation: all in-flight operations are discarded with no response. Requesters re-present after reset.

## Structure
- Package alu_pkg: OPC_W, DATA_W, opcode constants OP_AND=0, OP_OR=1, OP_XOR=2, OP_ADD=3, OP_SUB=4, and an illegal-opcode function.
- One sub-module: rr_arb2 (2-way round-robin grant with last_grant register, update on handshake).
- The ALU itself is external and is not instantiated here. The bench instantiates the existing bitwise/adder ALU behind alu_*.

## Test plan
- Req0 only, OR, a=AAAA_BBBB_CCCC_DDDD, b=1111_2222_3333_4444, rsp_ready=1 → rsp_valid one cycle after accept, rsp_id=0, rsp_data=BBBB_BBBB_FFFF_DDDD, rsp_err=0.
- Both valid every cycle for 6 cycles, rsp_ready=1 → grants 0,1,0,1,0,1, one response per cycle, ids in the same order.
- Req1 ADD FFFF_FFFF_FFFF_FFFF + 1 → rsp_data=0 (wrap), rsp_id=1. Req0 SUB 0−1 → FFFF_FFFF_FFFF_FFFF.
- rsp_ready=0 with 3 requests offered → exactly 2 accepted, then ready low. rsp_data stable. On rsp_ready=1, both responses appear in order and the third request is accepted the same cycle.
- Illegal opcode 3'b110 → rsp_err=1, rsp_data=0, and the next legal operation is unaffected.
- rst_n low for one cycle while both stages are full → rsp_valid=0 and s1 empty immediately. Post-reset tie grants requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcode encodings and opcode legality test for the
// arbitrated ALU issue pipeline (alu_arbiter_64) and its external ALU.
package alu_pkg;

   localparam int DATA_W = 64;
   localparam int OPC_W  = 3;

   localparam logic [OPC_W-1:0] OP_AND = 3'd0;
   localparam logic [OPC_W-1:0] OP_OR  = 3'd1;
   localparam logic [OPC_W-1:0] OP_XOR = 3'd2;
   localparam logic [OPC_W-1:0] OP_ADD = 3'd3;
   localparam logic [OPC_W-1:0] OP_SUB = 3'd4;

   // Encodings above OP_SUB (3'b101..3'b111) have no ALU meaning.
   function automatic logic is_illegal(input logic [OPC_W-1:0] op);
      return (op > OP_SUB);
   endfunction

endpackage

// File: rtl/alu_arbiter_64_rr_arb2.sv
// rr_arb2: two-way round-robin grant.
//   clk, rst_n  : clock, asynchronous active-low reset
//   valid0/1    : request present from requester 0/1
//   handshake   : the granted request was accepted this cycle
//   grant       : index of the requester currently granted
// A lone valid requester always wins; on a tie the requester that did not
// win the last accepted handshake wins. last_grant resets to 1 so that
// requester 0 wins the first tie.
module rr_arb2 (
   input  logic clk,
   input  logic rst_n,
   input  logic valid0,
   input  logic valid1,
   input  logic handshake,
   output logic grant
);

   logic last_grant;

   // Grant 1 when only requester 1 asks, or on a tie after 0 won last.
   always_comb begin
      grant = valid1 & (~valid0 | ~last_grant);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (handshake) begin
         last_grant <= grant;
      end
   end

endmodule

// File: rtl/alu_arbiter_64.sv
// alu_arbiter_64: two-requester round-robin front end and two-stage issue
// pipeline around one shared external combinational 64-bit ALU.
//   clk, rst_n            : clock, asynchronous active-low reset
//   reqN_valid/ready      : request handshake for requester N (0/1)
//   reqN_op, reqN_a/b     : opcode and operands of requester N
//   alu_op, alu_a, alu_b  : issue-register contents driving the shared ALU
//   alu_y                 : combinational ALU result for alu_op/alu_a/alu_b
//   rsp_valid/ready       : response handshake
//   rsp_id                : requester that issued the operation
//   rsp_data, rsp_err     : result (forced to 0 on illegal opcode), error flag
// S1 (issue register) holds the winning request; S2 (response register)
// captures the ALU result. Drain, S1->S2 move and accept can all happen in
// the same cycle, so one operation per cycle flows when rsp_ready stays high.
module alu_arbiter_64
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OPC_W-1:0]  req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OPC_W-1:0]  req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic [OPC_W-1:0]  alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_y,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err
);

   logic              grant;
   logic              s1_valid;
   logic              s1_id;
   logic [OPC_W-1:0]  s1_op;
   logic [DATA_W-1:0] s1_a;
   logic [DATA_W-1:0] s1_b;
   logic              s2_free;
   logic              s1_free;
   logic              accept;
   logic              move;

   // A stage is free if empty or if its content leaves this cycle.
   assign s2_free = ~rsp_valid | rsp_ready;
   assign s1_free = ~s1_valid | s2_free;

   // Readiness depends only on valids, arbitration state and pipeline
   // occupancy, never on request payload.
   assign req0_ready = s1_free & ~grant;
   assign req1_ready = s1_free &  grant;

   assign accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);
   assign move   = s1_valid & s2_free;

   rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid0    (req0_valid),
      .valid1    (req1_valid),
      .handshake (accept),
      .grant     (grant)
   );

   // S1: issue register, drives the shared ALU
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_id    <= 1'b0;
         s1_op    <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_id    <= grant;
         s1_op    <= grant ? req1_op : req0_op;
         s1_a     <= grant ? req1_a  : req0_a;
         s1_b     <= grant ? req1_b  : req0_b;
      end else if (move) begin
         s1_valid <= 1'b0;
      end
   end

   assign alu_op = s1_op;
   assign alu_a  = s1_a;
   assign alu_b  = s1_b;

   // S2: response register, captures the ALU result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else if (move) begin
         rsp_valid <= 1'b1;
         rsp_id    <= s1_id;
         rsp_data  <= is_illegal(s1_op) ? '0 : alu_y;
         rsp_err   <= is_illegal(s1_op);
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter_64.sv
module tb_alu_arbiter_64;
   import alu_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req0_valid = 1'b0, req1_valid = 1'b0;
   logic              req0_ready, req1_ready;
   logic [OPC_W-1:0]  req0_op = '0, req1_op = '0;
   logic [DATA_W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [OPC_W-1:0]  alu_op;
   logic [DATA_W-1:0] alu_a, alu_b, alu_y;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic              rsp_id;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   int checks = 0;
   int errors = 0;
   int acc_count = 0;
   int rsp_count = 0;

   typedef struct packed {
      logic              id;
      logic [DATA_W-1:0] data;
      logic              err;
   } rsp_t;

   rsp_t sb[$];
   logic acc_ids[$];

   always #5 clk = ~clk;

   alu_arbiter_64 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_y      (alu_y),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err)
   );

   // External shared ALU; illegal opcodes yield a non-zero value so that
   // the forced-zero response is observable.
   always_comb begin
      case (alu_op)
         OP_AND:  alu_y = alu_a & alu_b;
         OP_OR:   alu_y = alu_a | alu_b;
         OP_XOR:  alu_y = alu_a ^ alu_b;
         OP_ADD:  alu_y = alu_a + alu_b;
         OP_SUB:  alu_y = alu_a - alu_b;
         default: alu_y = alu_a + alu_b + 64'd1;
      endcase
   end

   function automatic rsp_t model(input logic id, input logic [OPC_W-1:0] op,
                                  input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      rsp_t r;
      r.id  = id;
      r.err = 1'b0;
      case (op)
         3'd0:    r.data = a & b;
         3'd1:    r.data = a | b;
         3'd2:    r.data = a ^ b;
         3'd3:    r.data = a + b;
         3'd4:    r.data = a - b;
         default: begin r.data = '0; r.err = 1'b1; end
      endcase
      return r;
   endfunction

   // Scoreboard: push on request handshake, pop on response handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         rsp_t got, exp;
         checks++;
         if (req0_ready && req1_ready) begin
            errors++;
            $display("FAIL one_ready got req0_ready=%0b req1_ready=%0b exp at most one", req0_ready, req1_ready);
         end
         if (req0_valid && req0_ready) begin
            sb.push_back(model(1'b0, req0_op, req0_a, req0_b));
            acc_ids.push_back(1'b0);
            acc_count++;
         end
         if (req1_valid && req1_ready) begin
            sb.push_back(model(1'b1, req1_op, req1_a, req1_b));
            acc_ids.push_back(1'b1);
            acc_count++;
         end
         if (rsp_valid && rsp_ready) begin
            rsp_count++;
            got = '{id: rsp_id, data: rsp_data, err: rsp_err};
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected got id=%0b data=%h err=%0b exp no response", rsp_id, rsp_data, rsp_err);
            end else begin
               exp = sb.pop_front();
               if (got !== exp) begin
                  errors++;
                  $display("FAIL sb_rsp got id=%0b data=%h err=%0b exp id=%0b data=%h err=%0b",
                           got.id, got.data, got.err, exp.id, exp.data, exp.err);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic drive(input logic id, input logic [OPC_W-1:0] op,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      if (id) begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end
   endtask

   // Issue one request and wait (bounded) until its response is presented.
   task automatic issue_one(input logic id, input logic [OPC_W-1:0] op,
                            input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            output logic ok);
      int n;
      ok = 1'b1;
      step();
      rsp_ready = 1'b1;
      drive(id, op, a, b);
      n = 0;
      @(negedge clk);
      while (!(id ? req1_ready : req0_ready) && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10) begin
         checks++; errors++; ok = 1'b0;
         $display("FAIL accept_timeout got no ready exp ready within 10 cycles");
      end
      step();
      idle();
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10) begin
         checks++; errors++; ok = 1'b0;
         $display("FAIL rsp_timeout got no rsp_valid exp rsp within 10 cycles");
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      rsp_ready = 1'b0;
      repeat (2) step();
      drive(1'b0, OP_AND, 64'h1, 64'h2);
      drive(1'b1, OP_AND, 64'h3, 64'h4);
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
      checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %0b exp 0", rsp_id); end
      checks++; if (rsp_data !== 64'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %0b exp 0", rsp_err); end
      checks++; if ({alu_op, alu_a, alu_b} !== '0) begin errors++; $display("FAIL reset_alu got op=%0d a=%h b=%h exp 0", alu_op, alu_a, alu_b); end
      checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL reset_tie got r0=%0b r1=%0b exp r0=1 r1=0", req0_ready, req1_ready); end
      step();
      idle();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      rsp_ready = 1'b1;
      drive(1'b0, OP_OR, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444);
      @(negedge clk);
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %0b exp 1", req0_ready); end
      step();
      idle();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_latency_early got rsp_valid=%0b exp 0", rsp_valid); end
      checks++; if (alu_op !== OP_OR || alu_a !== 64'hAAAA_BBBB_CCCC_DDDD) begin errors++; $display("FAIL single_issue got op=%0d a=%h exp op=1 a=aaaabbbbccccdddd", alu_op, alu_a); end
      step();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_latency got rsp_valid=%0b exp 1", rsp_valid); end
      checks++; if (rsp_id !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL single_id_err got id=%0b err=%0b exp 0 0", rsp_id, rsp_err); end
      checks++; if (rsp_data !== 64'hBBBB_BBBB_FFFF_DDDD) begin errors++; $display("FAIL single_data got %h exp bbbbbbbbffffdddd", rsp_data); end
      step();
   endtask

   task automatic test_round_robin();
      int r0;
      rsp_ready = 1'b1;
      // Prime with a lone requester-1 operation so the next tie goes to 0.
      drive(1'b1, OP_AND, 64'hF0F0, 64'hFF00);
      step();
      acc_ids.delete();
      r0 = rsp_count;
      drive(1'b0, 3'($urandom_range(0, 4)), {$urandom, $urandom}, {$urandom, $urandom});
      drive(1'b1, 3'($urandom_range(0, 4)), {$urandom, $urandom}, {$urandom, $urandom});
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checks++;
            if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_throughput cycle %0d got rsp_valid=%0b exp 1", i, rsp_valid); end
         end
         step();
         drive(1'b0, 3'($urandom_range(0, 4)), {$urandom, $urandom}, {$urandom, $urandom});
         drive(1'b1, 3'($urandom_range(0, 4)), {$urandom, $urandom}, {$urandom, $urandom});
      end
      idle();
      repeat (3) step();
      checks++;
      if (acc_ids.size() != 6) begin
         errors++; $display("FAIL rr_count got %0d exp 6", acc_ids.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (acc_ids[i] !== 1'(i % 2)) begin errors++; $display("FAIL rr_grant %0d got %0b exp %0b", i, acc_ids[i], 1'(i % 2)); end
         end
      end
      checks++; if (rsp_count - r0 != 7) begin errors++; $display("FAIL rr_rsp_count got %0d exp 7", rsp_count - r0); end
   endtask

   task automatic test_wrap();
      logic ok;
      issue_one(1'b1, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, ok);
      if (ok) begin
         checks++; if (rsp_data !== 64'h0 || rsp_id !== 1'b1) begin errors++; $display("FAIL add_wrap got id=%0b data=%h exp id=1 data=0", rsp_id, rsp_data); end
      end
      issue_one(1'b0, OP_SUB, 64'h0, 64'h1, ok);
      if (ok) begin
         checks++; if (rsp_data !== 64'hFFFF_FFFF_FFFF_FFFF || rsp_id !== 1'b0) begin errors++; $display("FAIL sub_wrap got id=%0b data=%h exp id=0 data=ffffffffffffffff", rsp_id, rsp_data); end
      end
      step();
   endtask

   task automatic test_backpressure();
      int a0;
      logic [DATA_W-1:0] held;
      rsp_ready = 1'b0;
      a0 = acc_count;
      drive(1'b0, OP_XOR, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000);
      drive(1'b1, OP_ADD, 64'h1000_0000_0000_0001, 64'h0000_0000_0000_0FFF);
      repeat (4) step();
      @(negedge clk);
      checks++; if (acc_count - a0 != 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", acc_count - a0); end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got r0=%0b r1=%0b exp 0 0", req0_ready, req1_ready); end
      held = rsp_data;
      repeat (2) step();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== held) begin errors++; $display("FAIL bp_stable got valid=%0b data=%h exp valid=1 data=%h", rsp_valid, rsp_data, held); end
      step();
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++; if ((req0_ready | req1_ready) !== 1'b1) begin errors++; $display("FAIL bp_release_ready got r0=%0b r1=%0b exp one high", req0_ready, req1_ready); end
      step();
      checks++; if (acc_count - a0 != 3) begin errors++; $display("FAIL bp_third_accept got %0d exp 3", acc_count - a0); end
      idle();
      repeat (4) step();
   endtask

   task automatic test_illegal();
      logic ok;
      issue_one(1'b0, 3'b110, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, ok);
      if (ok) begin
         checks++; if (rsp_err !== 1'b1 || rsp_data !== 64'h0) begin errors++; $display("FAIL illegal got err=%0b data=%h exp err=1 data=0", rsp_err, rsp_data); end
      end
      issue_one(1'b1, OP_XOR, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, ok);
      if (ok) begin
         checks++; if (rsp_err !== 1'b0 || rsp_data !== 64'hF00F_F00F_F00F_F00F) begin errors++; $display("FAIL after_illegal got err=%0b data=%h exp err=0 data=f00ff00ff00ff00f", rsp_err, rsp_data); end
      end
      step();
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      drive(1'b0, OP_AND, 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF);
      drive(1'b1, OP_OR,  64'h0000_0000_0000_00AA, 64'h0000_0000_0000_5500);
      repeat (3) step();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL midreset_pre got rsp_valid=%0b exp 1", rsp_valid); end
      step();
      rst_n = 1'b0;
      sb.delete();
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_rsp got rsp_valid=%0b exp 0", rsp_valid); end
      checks++; if (alu_a !== 64'h0 || alu_b !== 64'h0) begin errors++; $display("FAIL midreset_s1 got a=%h b=%h exp 0 0", alu_a, alu_b); end
      step();
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      acc_ids.delete();
      step();
      idle();
      checks++;
      if (acc_ids.size() == 0) begin
         errors++; $display("FAIL post_reset_tie got no grant exp requester 0");
      end else if (acc_ids[0] !== 1'b0) begin
         errors++; $display("FAIL post_reset_tie got %0b exp 0", acc_ids[0]);
      end
      repeat (4) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_backpressure();
      test_illegal();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
